// File: rtl/mca_lut_fir_engine_pkg.sv
// mca_lut_fir_engine_pkg
//   Shared types and helpers for the LUT-grouped FIR accumulation engine.
//   - mca_state_e : sequencer states
//   - calc_*      : derived sizes (groups, terms, beats, LUT address width)
//   - sat_narrow  : signed narrowing to an arbitrary width, clamp or wrap
package mca_lut_fir_engine_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } mca_state_e;

    function automatic int calc_g(input int k, input int lut_bits);
        return k / lut_bits;
    endfunction

    function automatic int calc_t(input int n, input int k, input int lut_bits);
        return n * calc_g(k, lut_bits);
    endfunction

    function automatic int calc_b(input int n, input int k, input int lut_bits, input int lanes);
        return calc_t(n, k, lut_bits) / lanes;
    endfunction

    function automatic int calc_aw(input int n, input int k, input int lut_bits);
        return $clog2(calc_t(n, k, lut_bits) * (1 << lut_bits));
    endfunction

    // Narrows a sign-extended 64-bit value to w bits. The result is returned
    // sign-extended to 64 bits; callers keep the low w bits.
    function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] v,
                                                      input int w,
                                                      input bit sat);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (!sat) begin
            return (v <<< (64 - w)) >>> (64 - w);
        end
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/mca_lane_adder_tree.sv
// mca_lane_adder_tree
//   Sign-extends LANES coefficients to WIDTH_ACC, sums them and registers
//   the result as lane_sum when en is high.
//   Ports: clk, reset (sync, active-high), en, coef_data[LANES], lane_sum.
module mca_lane_adder_tree
    import mca_lut_fir_engine_pkg::*;
#(
    parameter int LANES             = 8,
    parameter int WIDTH_COEFFICIENT = 32,
    parameter int WIDTH_ACC         = 40
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            en,
    input  logic signed [LANES-1:0][WIDTH_COEFFICIENT-1:0]  coef_data,
    output logic signed [WIDTH_ACC-1:0]                     lane_sum
);

    logic signed [WIDTH_ACC-1:0] sum_comb;

    // Packed-array elements are unsigned, so each lane is re-signed before
    // being extended.
    always_comb begin
        sum_comb = '0;
        for (int l = 0; l < LANES; l++) begin
            sum_comb = sum_comb + WIDTH_ACC'($signed(coef_data[l]));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_sum <= '0;
        end else if (en) begin
            lane_sum <= sum_comb;
        end
    end

endmodule

// File: rtl/mca_lut_fir_engine.sv
// mca_lut_fir_engine
//   Time-multiplexed FIR engine: snapshots the N x K control-bit matrix on an
//   accepted start, fetches one LUT coefficient per (state, group) term,
//   LANES terms per cycle, accumulates, and emits one narrowed sample.
//   Ports: clk, reset (sync, active-high), start/ready handshake, S_matrix,
//   coef_en/coef_addr (LUT read request), coef_data (1-cycle read latency),
//   sample/sample_valid (result and one-cycle strobe).
//
//   state | meaning
//   IDLE  | ready for start; snapshot taken on accept
//   FETCH | issue one beat of LANES addresses per cycle
//   DRAIN | wait for the last lane_sum, then emit the sample
module mca_lut_fir_engine
    import mca_lut_fir_engine_pkg::*;
#(
    parameter int K                 = 256,
    parameter int N                 = 8,
    parameter int WIDTH_COEFFICIENT = 32,
    parameter int WIDTH_ACC         = 40,
    parameter int LUT_BITS          = 2,
    parameter int LANES             = 8,
    parameter int SATURATE          = 1,
    localparam int AW               = calc_aw(N, K, LUT_BITS)
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            start,
    output logic                                            ready,
    input  logic [K-1:0][N-1:0]                             S_matrix,
    output logic                                            coef_en,
    output logic [LANES-1:0][AW-1:0]                        coef_addr,
    input  logic signed [LANES-1:0][WIDTH_COEFFICIENT-1:0]  coef_data,
    output logic signed [WIDTH_COEFFICIENT-1:0]             sample,
    output logic                                            sample_valid
);

    localparam int G  = calc_g(K, LUT_BITS);
    localparam int B  = calc_b(N, K, LUT_BITS, LANES);
    localparam int BW = (B > 1) ? $clog2(B) : 1;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int NW = (N > 1) ? $clog2(N) : 1;

    mca_state_e                  state, next_state;
    logic [K-1:0][N-1:0]         s_snap;
    logic [BW-1:0]               beat;
    logic                        last_beat;
    logic                        addr_live;
    logic                        accept;
    // Valid/last flags travelling alongside the fetched data.
    logic                        fetch_v, fetch_last;
    logic                        sum_v, sum_last;
    logic signed [WIDTH_ACC-1:0] acc, lane_sum, acc_final;

    assign last_beat = (beat == BW'(B - 1));
    assign accept    = ready & start;
    assign acc_final = acc + lane_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        coef_en    = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                coef_en = 1'b1;
                if (last_beat) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (sum_last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Addresses are forced to zero until the first accept after reset; after
    // that the beat counter parks on B-1 so the last beat's addresses hold.
    for (genvar l = 0; l < LANES; l++) begin : g_addr
        int                  t_idx;
        logic [LUT_BITS-1:0] sel;
        always_comb begin
            t_idx = int'(beat) * LANES + l;
            sel   = '0;
            for (int j = 0; j < LUT_BITS; j++) begin
                sel[j] = s_snap[KW'((t_idx % G) * LUT_BITS + j)][NW'(t_idx / G)];
            end
            coef_addr[l] = addr_live ? AW'(t_idx * (2 ** LUT_BITS) + int'(sel)) : '0;
        end
    end

    mca_lane_adder_tree #(
        .LANES             (LANES),
        .WIDTH_COEFFICIENT (WIDTH_COEFFICIENT),
        .WIDTH_ACC         (WIDTH_ACC)
    ) u_adder (
        .clk       (clk),
        .reset     (reset),
        .en        (fetch_v),
        .coef_data (coef_data),
        .lane_sum  (lane_sum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s_snap       <= '0;
            beat         <= '0;
            addr_live    <= 1'b0;
            fetch_v      <= 1'b0;
            fetch_last   <= 1'b0;
            sum_v        <= 1'b0;
            sum_last     <= 1'b0;
            acc          <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            fetch_v      <= coef_en;
            fetch_last   <= coef_en & last_beat;
            sum_v        <= fetch_v;
            sum_last     <= fetch_last;
            if (accept) begin
                s_snap    <= S_matrix;
                beat      <= '0;
                acc       <= '0;
                addr_live <= 1'b1;
            end else begin
                if (coef_en && !last_beat) begin
                    beat <= beat + BW'(1);
                end
                if (sum_v) begin
                    acc <= acc_final;
                end
            end
            // The final lane_sum is folded in directly so the result lands
            // one edge earlier than going through acc.
            if (sum_last) begin
                sample       <= WIDTH_COEFFICIENT'(sat_narrow(64'(acc_final),
                                                             WIDTH_COEFFICIENT,
                                                             SATURATE != 0));
                sample_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mca_lut_fir_engine.sv
// tb_mca_lut_fir_engine
//   Three small engine instances (N=2, K=4, LUT_BITS=2, LANES=2, so B=2 and
//   latency 4): a = W16/ACC20 clamp with LUT word 16t+sel, b = W8/ACC12 clamp,
//   c = W8/ACC12 wrap, both b and c with a constant LUT word.
//   Expected samples are queued at issue time and popped by a monitor.
module tb_mca_lut_fir_engine;

    localparam int LAT = 4;

    typedef struct {
        int val;
        int due;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    logic                     start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic                     ready_a, ready_b, ready_c;
    logic [3:0][1:0]          S_a = '0;
    logic [3:0][1:0]          S_bc = '0;
    logic                     coef_en_a, coef_en_b, coef_en_c;
    logic [1:0][3:0]          coef_addr_a, coef_addr_b, coef_addr_c;
    logic signed [1:0][15:0]  data_a = '0;
    logic signed [1:0][7:0]   data_b = '0;
    logic signed [1:0][7:0]   data_c = '0;
    logic signed [15:0]       sample_a;
    logic signed [7:0]        sample_b, sample_c;
    logic                     sample_valid_a, sample_valid_b, sample_valid_c;
    int                       word_b = 100;
    int                       word_c = 100;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mca_lut_fir_engine #(.K(4), .N(2), .WIDTH_COEFFICIENT(16), .WIDTH_ACC(20),
                         .LUT_BITS(2), .LANES(2), .SATURATE(1)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .ready(ready_a),
        .S_matrix(S_a), .coef_en(coef_en_a), .coef_addr(coef_addr_a),
        .coef_data(data_a), .sample(sample_a), .sample_valid(sample_valid_a));

    mca_lut_fir_engine #(.K(4), .N(2), .WIDTH_COEFFICIENT(8), .WIDTH_ACC(12),
                         .LUT_BITS(2), .LANES(2), .SATURATE(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .ready(ready_b),
        .S_matrix(S_bc), .coef_en(coef_en_b), .coef_addr(coef_addr_b),
        .coef_data(data_b), .sample(sample_b), .sample_valid(sample_valid_b));

    mca_lut_fir_engine #(.K(4), .N(2), .WIDTH_COEFFICIENT(8), .WIDTH_ACC(12),
                         .LUT_BITS(2), .LANES(2), .SATURATE(0)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .ready(ready_c),
        .S_matrix(S_bc), .coef_en(coef_en_c), .coef_addr(coef_addr_c),
        .coef_data(data_c), .sample(sample_c), .sample_valid(sample_valid_c));

    // LUT memories with one cycle of read latency.
    always @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (coef_en_a)
                data_a[l] <= 16'(16 * int'(coef_addr_a[l][3:2]) + int'(coef_addr_a[l][1:0]));
            if (coef_en_b)
                data_b[l] <= 8'(word_b);
            if (coef_en_c)
                data_c[l] <= 8'(word_c);
        end
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic score(input string nm, input int act, input exp_t e);
        chk({nm, "_value"}, act, e.val);
        chk({nm, "_cycle"}, cyc, e.due);
    endtask

    task automatic unexpected(input string nm, input int act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s_unexpected_valid: got sample %0d expected no valid", nm, act);
    endtask

    always @(negedge clk) begin
        if (sample_valid_a) begin
            if (q_a.size() == 0) unexpected("a", int'(sample_a));
            else score("a", int'(sample_a), q_a.pop_front());
        end
        if (sample_valid_b) begin
            if (q_b.size() == 0) unexpected("b", int'(sample_b));
            else score("b", int'(sample_b), q_b.pop_front());
        end
        if (sample_valid_c) begin
            if (q_c.size() == 0) unexpected("c", int'(sample_c));
            else score("c", int'(sample_c), q_c.pop_front());
        end
    end

    // Returns at the falling edge just after the accept edge.
    task automatic issue(input int which, input logic [7:0] s, input int expv, input bit push);
        exp_t e;
        @(negedge clk);
        e.val = expv;
        e.due = cyc + 1 + LAT;
        case (which)
            0: begin S_a = s; start_a = 1'b1; if (push) q_a.push_back(e); end
            1: begin start_b = 1'b1; if (push) q_b.push_back(e); end
            default: begin start_c = 1'b1; if (push) q_c.push_back(e); end
        endcase
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    task automatic wait_drain();
        int left;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (q_a.size() + q_b.size() + q_c.size() == 0) break;
        end
        left = q_a.size() + q_b.size() + q_c.size();
        if (left != 0) begin
            chk("drain_timeout", left, 0);
            q_a.delete();
            q_b.delete();
            q_c.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_a_addr(input logic [7:0] s, input int expv,
                              input int a0, input int a1, input int a2, input int a3);
        issue(0, s, expv, 1'b1);
        chk("beat0_en", int'(coef_en_a), 1);
        chk("beat0_addr0", int'(coef_addr_a[0]), a0);
        chk("beat0_addr1", int'(coef_addr_a[1]), a1);
        @(negedge clk);
        chk("beat1_addr0", int'(coef_addr_a[0]), a2);
        chk("beat1_addr1", int'(coef_addr_a[1]), a3);
        @(negedge clk);
        chk("drain_en", int'(coef_en_a), 0);
        chk("drain_addr1", int'(coef_addr_a[1]), a3);
        wait_drain();
    endtask

    initial begin
        bit found;
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(ready_a), 1);
        chk("rst_sample", int'(sample_a), 0);
        chk("rst_valid", int'(sample_valid_a), 0);
        chk("rst_coef_en", int'(coef_en_a), 0);
        chk("rst_addr0", int'(coef_addr_a[0]), 0);
        chk("rst_addr1", int'(coef_addr_a[1]), 0);
        reset = 1'b0;
        @(negedge clk);

        // Directed sums with hand-computed addresses.
        run_a_addr(8'h00, 96, 0, 4, 8, 12);
        run_a_addr(8'hFF, 108, 3, 7, 11, 15);

        // Single-bit mapping: S[k][n] sits at bit k*2+n.
        issue(0, 8'h01, 97, 1'b1);  wait_drain();   // t0 sel=1
        issue(0, 8'h08, 98, 1'b1);  wait_drain();   // S[1][1]: t2 sel=2
        issue(0, 8'h20, 97, 1'b1);  wait_drain();   // S[2][1]: t3 sel=1
        issue(0, 8'h55, 102, 1'b1); wait_drain();   // n=0 all ones: t0,t1 sel=3

        // Back-to-back, with S changed under the first run.
        issue(0, 8'h00, 96, 1'b1);
        S_a = 8'hAA;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (sample_valid_a) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("b2b_first_valid_seen", int'(found), 1);
        if (found) begin
            exp_t e;
            e.val = 108;
            e.due = cyc + 1 + LAT;
            S_a = 8'hFF;
            start_a = 1'b1;
            q_a.push_back(e);
            @(negedge clk);
            start_a = 1'b0;
            S_a = 8'h00;
        end
        wait_drain();

        // start while busy is ignored.
        issue(0, 8'h01, 97, 1'b1);
        S_a = 8'hFF;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_drain();
        repeat (6) @(negedge clk);
        chk("busy_start_sample_held", int'(sample_a), 97);

        // Reset two cycles after accept.
        issue(0, 8'h00, 96, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_ready", int'(ready_a), 1);
        chk("midrst_sample", int'(sample_a), 0);
        chk("midrst_valid", int'(sample_valid_a), 0);
        chk("midrst_coef_en", int'(coef_en_a), 0);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        issue(0, 8'h00, 96, 1'b1);
        wait_drain();

        // Narrowing: clamp and wrap.
        word_b = 100;  issue(1, 8'h00, 127, 1'b1);  wait_drain();
        word_b = -100; issue(1, 8'h00, -128, 1'b1); wait_drain();
        word_b = 30;   issue(1, 8'h00, 120, 1'b1);  wait_drain();
        word_c = 100;  issue(2, 8'h00, -112, 1'b1); wait_drain();
        word_c = -100; issue(2, 8'h00, 112, 1'b1);  wait_drain();

        repeat (4) @(negedge clk);
        chk("queues_empty", q_a.size() + q_b.size() + q_c.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule
